// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit counter encodings,
// the BTB entry layout and saturating arithmetic.
package bp_pkg;

    // Tag and target fields are stored at this width; XLEN must not exceed it.
    localparam int unsigned BP_XLEN = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic               valid;
        logic [BP_XLEN-1:0] tag;
        logic [BP_XLEN-1:0] target;
        ctr_e               ctr;
    } bp_entry_t;

    localparam bp_entry_t BP_ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};

    // Strengthen towards strongly-taken, holding at ST.
    function automatic ctr_e ctr_sat_inc(input ctr_e c);
        ctr_e r;
        unique case (c)
            SNT:     r = WNT;
            WNT:     r = WT;
            default: r = ST;
        endcase
        return r;
    endfunction

    // Weaken towards strongly-not-taken, holding at SNT.
    function automatic ctr_e ctr_sat_dec(input ctr_e c);
        ctr_e r;
        unique case (c)
            ST:      r = WT;
            WT:      r = WNT;
            default: r = SNT;
        endcase
        return r;
    endfunction

    // Upper half of the counter range predicts taken.
    function automatic logic ctr_taken(input ctr_e c);
        return (c == WT) || (c == ST);
    endfunction

    // 32-bit event counter step that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] cnt_sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped branch target buffer storage: two asynchronous read ports
// (Fetch, Execute) and one synchronous write port. Reads return the
// pre-write contents during a write cycle.
module bp_table
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDXW    = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IDXW-1:0] f_idx,
    output bp_entry_t       f_entry,
    input  logic [IDXW-1:0] e_idx,
    output bp_entry_t       e_entry,
    input  logic            we,
    input  logic [IDXW-1:0] w_idx,
    input  bp_entry_t       w_entry
);

    bp_entry_t mem_q [ENTRIES];
    bp_entry_t mem_d [ENTRIES];

    // Read ports look at the registered array, so a same-cycle write is not yet visible.
    assign f_entry = mem_q[f_idx];
    assign e_entry = mem_q[e_idx];

    // Next-state of the array: hold everything, replace the written entry.
    always_comb begin
        // NOTE: default every element first so no path leaves mem_d unassigned (no latch).
        mem_d = mem_q;
        if (we) begin
            mem_d[w_idx] = w_entry;
        end
    end

    // Array register; reset invalidates every entry and returns counters to WNT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this table is small flop storage, so it is reset; a RAM macro would not be.
            for (int i = 0; i < int'(ENTRIES); i++) begin
                mem_q[i] <= BP_ENTRY_RESET;
            end
        end else begin
            // NOTE: non-blocking so every read port sees the old value within this edge.
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor and redirect controller: Fetch-side BTB lookup,
// Execute-side mispredict/redirect, table training and performance counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] F_PC,
    output logic            F_PredTaken,
    output logic [XLEN-1:0] F_PredTarget,
    input  logic            E_Valid,
    input  logic            E_Branch,
    input  logic            E_Jump,
    input  logic            E_PCSrc,
    input  logic [XLEN-1:0] E_PC,
    input  logic [XLEN-1:0] E_Target,
    input  logic            E_PredTaken,
    input  logic [XLEN-1:0] E_PredTarget,
    output logic            E_Mispredict,
    output logic [XLEN-1:0] E_RedirectPC,
    output logic [31:0]     BranchCount,
    output logic [31:0]     MispredCount
);

    localparam int unsigned IDXW = $clog2(ENTRIES);

    logic [IDXW-1:0]    f_idx;
    logic [IDXW-1:0]    e_idx;
    logic [BP_XLEN-1:0] f_tag;
    logic [BP_XLEN-1:0] e_tag;
    bp_entry_t          f_entry;
    bp_entry_t          e_entry;
    logic               f_hit;
    logic               e_hit;
    logic               act;
    logic               table_we;
    bp_entry_t          w_entry;
    logic [31:0]        branch_cnt_q, branch_cnt_d;
    logic [31:0]        mispred_cnt_q, mispred_cnt_d;

    // Instruction alignment bits never select a BTB entry.
    logic unused_f_pc_lsbs;
    assign unused_f_pc_lsbs = ^F_PC[1:0];

    assign f_idx = F_PC[IDXW+1:2];
    assign e_idx = E_PC[IDXW+1:2];
    assign f_tag = BP_XLEN'(F_PC[XLEN-1:IDXW+2]);
    assign e_tag = BP_XLEN'(E_PC[XLEN-1:IDXW+2]);

    bp_table #(
        .ENTRIES (ENTRIES),
        .IDXW    (IDXW)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .f_idx   (f_idx),
        .f_entry (f_entry),
        .e_idx   (e_idx),
        .e_entry (e_entry),
        .we      (table_we),
        .w_idx   (e_idx),
        .w_entry (w_entry)
    );

    // Fetch prediction: taken only on a tag hit with a taken-leaning counter.
    always_comb begin
        f_hit        = f_entry.valid && (f_entry.tag == f_tag);
        F_PredTaken  = f_hit && ctr_taken(f_entry.ctr);
        F_PredTarget = F_PredTaken ? f_entry.target[XLEN-1:0] : '0;
    end

    // Resolve: compare actual outcome with the prediction carried from Fetch.
    always_comb begin
        act          = E_Valid && (E_Branch || E_Jump);
        E_Mispredict = act && ((E_PCSrc != E_PredTaken) ||
                               (E_PCSrc && E_PredTaken && (E_Target != E_PredTarget)));
        E_RedirectPC = '0;
        if (E_Mispredict) begin
            E_RedirectPC = E_PCSrc ? E_Target : E_PC + XLEN'(4);
        end
    end

    // Training decision: update counter/target on a hit, allocate on a taken miss.
    always_comb begin
        e_hit    = e_entry.valid && (e_entry.tag == e_tag);
        table_we = 1'b0;
        w_entry  = e_entry;
        if (act) begin
            if (e_hit) begin
                table_we = 1'b1;
                if (E_PCSrc) begin
                    w_entry.ctr    = ctr_sat_inc(e_entry.ctr);
                    w_entry.target = BP_XLEN'(E_Target);
                end else begin
                    w_entry.ctr    = ctr_sat_dec(e_entry.ctr);
                end
            end else if (E_PCSrc) begin
                table_we       = 1'b1;
                w_entry.valid  = 1'b1;
                w_entry.tag    = e_tag;
                w_entry.target = BP_XLEN'(E_Target);
                // Unconditional jumps start fully confident; branches start weakly taken.
                w_entry.ctr    = E_Jump ? ST : WT;
            end
        end
    end

    // Performance counter next-state; both stick at all-ones.
    always_comb begin
        branch_cnt_d  = act          ? cnt_sat_inc(branch_cnt_q)  : branch_cnt_q;
        mispred_cnt_d = E_Mispredict ? cnt_sat_inc(mispred_cnt_q) : mispred_cnt_q;
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BranchCount  = branch_cnt_q;
    assign MispredCount = mispred_cnt_q;

endmodule
